// File: rtl/game_fsm.sv
// Game controller for the N x N puzzle core: difficulty selection, map load
// handshake, cursor/number browsing, strike and time-limit tracking.
module game_fsm #(
    parameter int unsigned N            = 9,
    parameter int unsigned CW           = 4,
    parameter int unsigned LEVELS       = 2,
    parameter int unsigned STRIKE_LIMIT = 3,
    parameter int unsigned TW           = 11,
    parameter logic [LEVELS*TW-1:0] TIME_LIMITS = {11'd600, 11'd300}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              up_button,
    input  logic              down_button,
    input  logic              left_button,
    input  logic              right_button,
    input  logic              start_button,
    input  logic              a_button,
    input  logic              b_button,
    input  logic              map_valid,
    input  logic [N*N*CW-1:0] selected_map,
    input  logic [N*N-1:0]    selected_visibility,
    output logic              map_req,
    output logic [2:0]        state,
    output logic              playing,
    output logic [3:0]        pos_i,
    output logic [3:0]        pos_j,
    output logic [CW-1:0]     selected_number,
    output logic [CW-1:0]     cursor_value,
    output logic [N*N*CW-1:0] board,
    output logic [N*N-1:0]    visibilities,
    output logic [2:0]        strikes,
    output logic [TW-1:0]     elapsed,
    output logic [1:0]        difficulty,
    output logic              error
);

    localparam int unsigned CELLS = N * N;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        LOAD   = 3'd2,
        BROWSE = 3'd3,
        PICK   = 3'd4,
        PAUSE  = 3'd5,
        WIN    = 3'd6,
        LOSE   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        B_START, B_A, B_B, B_UP, B_DOWN, B_LEFT, B_RIGHT, B_NONE
    } btn_t;

    state_t              state_q, state_d;
    logic [3:0]          pos_i_q, pos_i_d, pos_j_q, pos_j_d;
    logic [CW-1:0]       sel_q, sel_d;
    logic [CELLS*CW-1:0] board_q, board_d;
    logic [CELLS-1:0]    vis_q, vis_d;
    logic [2:0]          strikes_q, strikes_d;
    logic [TW-1:0]       elapsed_q, elapsed_d;
    logic [1:0]          diff_q, diff_d;
    logic                error_q, error_d;

    btn_t                btn;
    int unsigned         cell_idx;
    logic [CW-1:0]       cur_val;
    logic                cur_vis;
    logic [TW-1:0]       limit;
    logic                defeat, victory, in_play;

    always_comb begin
        if      (start_button) btn = B_START;
        else if (a_button)     btn = B_A;
        else if (b_button)     btn = B_B;
        else if (up_button)    btn = B_UP;
        else if (down_button)  btn = B_DOWN;
        else if (left_button)  btn = B_LEFT;
        else if (right_button) btn = B_RIGHT;
        else                   btn = B_NONE;
    end

    always_comb begin
        cell_idx = int'(pos_i_q) * N + int'(pos_j_q);
        cur_val  = '0;
        cur_vis  = 1'b0;
        for (int unsigned c = 0; c < CELLS; c++) begin
            if (c == cell_idx) begin
                cur_val = board_q[c*CW +: CW];
                cur_vis = vis_q[c];
            end
        end
        limit = '0;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            if (int'(diff_q) == l) limit = TIME_LIMITS[l*TW +: TW];
        end
        in_play = (state_q == BROWSE) || (state_q == PICK);
        defeat  = (strikes_q >= 3'(STRIKE_LIMIT)) ||
                  ((limit != '0) && (elapsed_q >= limit));
        victory = &vis_q;
    end

    always_comb begin
        state_d   = state_q;
        pos_i_d   = pos_i_q;
        pos_j_d   = pos_j_q;
        sel_d     = sel_q;
        board_d   = board_q;
        vis_d     = vis_q;
        strikes_d = strikes_q;
        elapsed_d = elapsed_q;
        diff_d    = diff_q;
        error_d   = 1'b0;

        if (in_play && tick && (elapsed_q != '1)) elapsed_d = elapsed_q + 1'b1;

        unique case (state_q)
            IDLE: if (btn == B_START) state_d = SELECT;
            SELECT: begin
                case (btn)
                    B_UP:   if (diff_q < 2'(LEVELS - 1)) diff_d = diff_q + 2'd1;
                    B_DOWN: if (diff_q != 2'd0) diff_d = diff_q - 2'd1;
                    B_A:    state_d = LOAD;
                    default: ;
                endcase
            end
            LOAD: begin
                if (map_valid) begin
                    board_d   = selected_map;
                    vis_d     = selected_visibility;
                    strikes_d = '0;
                    elapsed_d = '0;
                    pos_i_d   = '0;
                    pos_j_d   = '0;
                    sel_d     = CW'(1);
                    state_d   = BROWSE;
                end
            end
            BROWSE: begin
                if (defeat)       state_d = LOSE;
                else if (victory) state_d = WIN;
                else begin
                    case (btn)
                        B_START: state_d = PAUSE;
                        B_A: if (!cur_vis) begin
                            state_d = PICK;
                            sel_d   = CW'(1);
                        end
                        B_UP:    pos_i_d = (pos_i_q == 4'd0) ? 4'(N - 1) : pos_i_q - 4'd1;
                        B_DOWN:  pos_i_d = (pos_i_q == 4'(N - 1)) ? 4'd0 : pos_i_q + 4'd1;
                        B_LEFT:  pos_j_d = (pos_j_q == 4'd0) ? 4'(N - 1) : pos_j_q - 4'd1;
                        B_RIGHT: pos_j_d = (pos_j_q == 4'(N - 1)) ? 4'd0 : pos_j_q + 4'd1;
                        default: ;
                    endcase
                end
            end
            PICK: begin
                if (defeat)       state_d = LOSE;
                else if (victory) state_d = WIN;
                else begin
                    case (btn)
                        B_START: state_d = PAUSE;
                        B_A: begin
                            if (sel_q == cur_val) begin
                                for (int unsigned c = 0; c < CELLS; c++) begin
                                    if (c == cell_idx) vis_d[c] = 1'b1;
                                end
                                state_d = BROWSE;
                            end else begin
                                if (strikes_q != 3'd7) strikes_d = strikes_q + 3'd1;
                                error_d = 1'b1;
                            end
                        end
                        B_B:    state_d = BROWSE;
                        B_UP:   sel_d = (sel_q == CW'(N)) ? CW'(1) : sel_q + CW'(1);
                        B_DOWN: sel_d = (sel_q == CW'(1)) ? CW'(N) : sel_q - CW'(1);
                        default: ;
                    endcase
                end
            end
            PAUSE:    if (btn == B_START) state_d = BROWSE;
            WIN, LOSE: if (btn == B_START) state_d = SELECT;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pos_i_q   <= '0;
            pos_j_q   <= '0;
            sel_q     <= CW'(1);
            board_q   <= '0;
            vis_q     <= '0;
            strikes_q <= '0;
            elapsed_q <= '0;
            diff_q    <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_i_q   <= pos_i_d;
            pos_j_q   <= pos_j_d;
            sel_q     <= sel_d;
            board_q   <= board_d;
            vis_q     <= vis_d;
            strikes_q <= strikes_d;
            elapsed_q <= elapsed_d;
            diff_q    <= diff_d;
            error_q   <= error_d;
        end
    end

    assign map_req         = (state_q == LOAD);
    assign state           = state_q;
    assign playing         = in_play;
    assign pos_i           = pos_i_q;
    assign pos_j           = pos_j_q;
    assign selected_number = sel_q;
    assign cursor_value    = cur_vis ? cur_val : '0;
    assign board           = board_q;
    assign visibilities    = vis_q;
    assign strikes         = strikes_q;
    assign elapsed         = elapsed_q;
    assign difficulty      = diff_q;
    assign error           = error_q;

endmodule

// File: tb/tb_game_fsm.sv
// Bench for game_fsm: a rule-level game model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_game_fsm;

    localparam int N = 9;
    localparam int CW = 4;
    localparam int LEVELS = 2;
    localparam int STRIKE_LIMIT = 3;
    localparam int TW = 11;
    localparam int CELLS = N * N;
    localparam int ELMAX = (1 << TW) - 1;

    localparam int K_NONE  = 0;
    localparam int K_RIGHT = 1;
    localparam int K_LEFT  = 2;
    localparam int K_DOWN  = 4;
    localparam int K_UP    = 8;
    localparam int K_B     = 16;
    localparam int K_A     = 32;
    localparam int K_START = 64;
    localparam int K_MV    = 128;
    localparam int K_TICK  = 256;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic up_button = 1'b0, down_button = 1'b0, left_button = 1'b0, right_button = 1'b0;
    logic start_button = 1'b0, a_button = 1'b0, b_button = 1'b0;
    logic map_valid = 1'b0;
    logic [CELLS*CW-1:0] selected_map = '0;
    logic [CELLS-1:0]    selected_visibility = '0;

    logic              map_req, playing, error;
    logic [2:0]        state, strikes;
    logic [3:0]        pos_i, pos_j;
    logic [CW-1:0]     selected_number, cursor_value;
    logic [CELLS*CW-1:0] board;
    logic [CELLS-1:0]  visibilities;
    logic [TW-1:0]     elapsed;
    logic [1:0]        difficulty;

    int checks = 0;
    int errors = 0;

    game_fsm #(
        .N(N), .CW(CW), .LEVELS(LEVELS), .STRIKE_LIMIT(STRIKE_LIMIT), .TW(TW),
        .TIME_LIMITS({11'd600, 11'd300})
    ) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .up_button(up_button), .down_button(down_button),
        .left_button(left_button), .right_button(right_button),
        .start_button(start_button), .a_button(a_button), .b_button(b_button),
        .map_valid(map_valid), .selected_map(selected_map),
        .selected_visibility(selected_visibility),
        .map_req(map_req), .state(state), .playing(playing),
        .pos_i(pos_i), .pos_j(pos_j), .selected_number(selected_number),
        .cursor_value(cursor_value), .board(board), .visibilities(visibilities),
        .strikes(strikes), .elapsed(elapsed), .difficulty(difficulty), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [CELLS*CW-1:0] act,
                        input logic [CELLS*CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Game model: states as plain integers, board as an array of cell values.
    int m_state, m_pi, m_pj, m_sel, m_str, m_el, m_diff;
    bit m_err;
    int cells [CELLS];
    bit vis [CELLS];

    task automatic model_step();
        int pressed, idx, lim;
        bit play, lose, win;
        pressed = start_button ? 1 : a_button ? 2 : b_button ? 3 : up_button ? 4 :
                  down_button ? 5 : left_button ? 6 : right_button ? 7 : 0;
        play = (m_state == 3) || (m_state == 4);
        lim  = (m_diff == 0) ? 300 : 600;
        lose = (m_str >= STRIKE_LIMIT) || (lim != 0 && m_el >= lim);
        win  = 1;
        for (int c = 0; c < CELLS; c++) if (!vis[c]) win = 0;
        idx = m_pi * N + m_pj;
        m_err = 0;
        if (play && tick && m_el < ELMAX) m_el++;
        case (m_state)
            0: if (pressed == 1) m_state = 1;
            1: begin
                if (pressed == 4 && m_diff < LEVELS - 1) m_diff++;
                if (pressed == 5 && m_diff > 0) m_diff--;
                if (pressed == 2) m_state = 2;
            end
            2: if (map_valid) begin
                for (int c = 0; c < CELLS; c++) begin
                    cells[c] = int'(selected_map[c*CW +: CW]);
                    vis[c]   = selected_visibility[c];
                end
                m_str = 0; m_el = 0; m_pi = 0; m_pj = 0; m_sel = 1; m_state = 3;
            end
            3: begin
                if (lose) m_state = 7;
                else if (win) m_state = 6;
                else case (pressed)
                    1: m_state = 5;
                    2: if (!vis[idx]) begin m_state = 4; m_sel = 1; end
                    4: m_pi = (m_pi + N - 1) % N;
                    5: m_pi = (m_pi + 1) % N;
                    6: m_pj = (m_pj + N - 1) % N;
                    7: m_pj = (m_pj + 1) % N;
                    default: ;
                endcase
            end
            4: begin
                if (lose) m_state = 7;
                else if (win) m_state = 6;
                else case (pressed)
                    1: m_state = 5;
                    2: if (m_sel == cells[idx]) begin vis[idx] = 1; m_state = 3; end
                       else begin m_str = (m_str < 7) ? m_str + 1 : 7; m_err = 1; end
                    3: m_state = 3;
                    4: m_sel = m_sel % N + 1;
                    5: m_sel = (m_sel == 1) ? N : m_sel - 1;
                    default: ;
                endcase
            end
            5: if (pressed == 1) m_state = 3;
            default: if (pressed == 1) m_state = 1;
        endcase
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = 0; m_pi = 0; m_pj = 0; m_sel = 1; m_str = 0; m_el = 0;
            m_diff = 0; m_err = 0;
            for (int c = 0; c < CELLS; c++) begin cells[c] = 0; vis[c] = 0; end
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        logic [CELLS*CW-1:0] eb;
        logic [CELLS*CW-1:0] ev;
        int idx;
        eb = '0;
        ev = '0;
        for (int c = 0; c < CELLS; c++) begin
            eb[c*CW +: CW] = CW'(cells[c]);
            ev[c] = vis[c];
        end
        idx = m_pi * N + m_pj;
        chk("state", state, m_state);
        chk("playing", playing, (m_state == 3 || m_state == 4) ? 1 : 0);
        chk("map_req", map_req, (m_state == 2) ? 1 : 0);
        chk("pos_i", pos_i, m_pi);
        chk("pos_j", pos_j, m_pj);
        chk("selected_number", selected_number, m_sel);
        chk("cursor_value", cursor_value, vis[idx] ? cells[idx] : 0);
        chkw("board", board, eb);
        chkw("visibilities", {{(CELLS*CW-CELLS){1'b0}}, visibilities}, ev);
        chk("strikes", strikes, m_str);
        chk("elapsed", elapsed, m_el);
        chk("difficulty", difficulty, m_diff);
        chk("error", error, m_err);
    end

    task automatic step(input int v);
        {tick, map_valid, start_button, a_button, b_button,
         up_button, down_button, left_button, right_button} = 9'(v);
        @(negedge clk);
        {tick, map_valid, start_button, a_button, b_button,
         up_button, down_button, left_button, right_button} = '0;
    endtask

    // Cell (0,0) holds 5; others hold column+1. hide_all clears every given.
    task automatic load_map(input bit hide_all);
        for (int c = 0; c < CELLS; c++) begin
            selected_map[c*CW +: CW] = CW'((c == 0) ? 5 : (c % N) + 1);
            selected_visibility[c]   = hide_all ? 1'b0 : (c != 0);
        end
    endtask

    initial begin
        load_map(1'b0);
        repeat (2) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_sel", selected_number, 1);
        reset = 1'b1;

        // Difficulty saturation and load handshake
        step(K_START);           chk("to_select", state, 1);
        step(K_UP); step(K_UP);  chk("diff_sat", difficulty, 1);
        step(K_A);               chk("load_req", map_req, 1);
        step(K_NONE);            chk("load_wait", state, 2);
        step(K_MV);              chk("browse", state, 3);
        chk("req_drop", map_req, 0);

        // Cursor wrap
        step(K_UP);              chk("wrap_up", pos_i, 8);
        step(K_LEFT);            chk("wrap_left", pos_j, 8);
        step(K_DOWN); step(K_RIGHT);
        chk("wrap_back", {pos_i, pos_j}, 0);

        // Correct placement then win
        step(K_A);               chk("pick", state, 4);
        repeat (4) step(K_UP);   chk("sel5", selected_number, 5);
        step(K_A);               chk("placed", visibilities[0], 1);
        chk("placed_state", state, 3);
        step(K_NONE);            chk("win", state, 6);

        // Three wrong placements then lose
        step(K_START); step(K_A); step(K_MV); step(K_A);
        chk("pick2", state, 4);
        step(K_A);               chk("err1", error, 1);
        step(K_NONE);            chk("err1_drop", error, 0);
        step(K_A); step(K_NONE);
        step(K_A);               chk("strikes3", strikes, 3);
        chk("err3", error, 1);
        chk("still_pick", state, 4);
        step(K_NONE);            chk("lose_strikes", state, 7);
        step(K_START);           chk("reselect", state, 1);

        // Time limit at difficulty 0 with a pause midway
        step(K_DOWN);            chk("diff0", difficulty, 0);
        load_map(1'b1);
        step(K_A); step(K_MV);
        repeat (150) begin step(K_TICK); step(K_NONE); end
        chk("el150", elapsed, 150);
        step(K_START);           chk("paused", state, 5);
        repeat (10) step(K_TICK);
        chk("pause_frozen", elapsed, 150);
        step(K_START);           chk("resume", state, 3);
        repeat (149) begin step(K_TICK); step(K_NONE); end
        chk("el299", elapsed, 299);
        step(K_TICK);            chk("el300", elapsed, 300);
        chk("not_yet_lose", state, 3);
        step(K_NONE);            chk("lose_time", state, 7);

        // Simultaneous start+a, then reset mid-PICK
        load_map(1'b0);
        step(K_START); step(K_A); step(K_MV);
        step(K_START | K_A);     chk("start_prio", state, 5);
        step(K_START); step(K_A); step(K_UP);
        chk("pick3_sel", selected_number, 2);
        #2 reset = 1'b0;
        #1;
        chk("ar_state", state, 0);
        chk("ar_sel", selected_number, 1);
        chk("ar_pos", {pos_i, pos_j}, 0);
        chk("ar_board", (board == '0) ? 1 : 0, 1);
        chk("ar_vis", (visibilities == '0) ? 1 : 0, 1);
        chk("ar_misc", {strikes, elapsed, difficulty, error, map_req, playing}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step(K_START);           chk("after_reset", state, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
